ps2_drive_ctrl: RTL and testbench
=================================

PS2_DRIVE_CTRL -- requirements
Module: ps2_drive_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_000_000, is the number of CLOCK_50 cycles a partial prefix sequence may wait for its next byte before it is abandoned.
REQ-002 Parameter TMR_W, default 20, is the width of the timeout counter; it SHALL hold TIMEOUT_CYCLES.
REQ-003 CLOCK_50  in  1  is the single clock; all logic is rising-edge.
REQ-004 reset  in  1  is the reset; it is synchronous and active-high.
REQ-005 ps2_key_data  in  8  is the scancode byte from the PS2_Controller and is valid only when ps2_key_pressed=1.
REQ-006 ps2_key_pressed  in  1  is a one-cycle byte strobe.
REQ-007 accel  out  2  is the drive command: 2'b10 forward, 2'b01 backward, 2'b00 stop; it is registered.
REQ-008 steer  out  2  is the steer command: 2'b10 left, 2'b01 right, 2'b00 straight; it is registered.
REQ-009 estop  out  1  is a one-cycle pulse on an ESC make.
REQ-010 held  out  4  holds the {fwd,back,left,right} key-held flags; it is registered.
REQ-011 seq_err  out  1  is a one-cycle pulse when a prefix sequence times out.

Function
REQ-012 The decoder FSM SHALL have four states: IDLE, GOT_E0, GOT_F0 and GOT_E0F0; transitions occur only on ps2_key_pressed cycles, except on timeout.
REQ-013 IDLE: 0xE0 goes to GOT_E0, 0xF0 goes to GOT_F0, and any other byte is a non-extended make that stays in IDLE.
REQ-014 GOT_E0: 0xF0 goes to GOT_E0F0, and any other byte is an extended make that returns to IDLE.
REQ-015 GOT_F0 and GOT_E0F0: any byte is a break of a non-extended or extended key respectively, then the FSM returns to IDLE.
REQ-016 Key map: forward is 0x73 or E0 0x75; back is 0x72 or E0 0x72; left is 0x6B or E0 0x6B; right is 0x74 or E0 0x74; ESC is 0x76, non-extended only.
REQ-017 A make SHALL set its held bit and a break SHALL clear it; unmapped codes change nothing; a repeated make (typematic) of an already-held key changes nothing.
REQ-018 Axis arbitration: when only one key of an axis is held, that direction is output; when neither is held, 2'b00 is output; when both are held, the most recently pressed key wins.
REQ-019 When the winning key of a both-held axis breaks, the other held key SHALL take over on the next cycle.
REQ-020 accel, steer and held SHALL update in the cycle after the final byte of a sequence is strobed, giving 1-cycle latency.
REQ-021 ESC make SHALL clear all held bits, force accel and steer to 2'b00, and pulse estop, all in the same update cycle.
REQ-022 The timeout counter SHALL run only in the GOT_E0, GOT_F0 and GOT_E0F0 states and SHALL clear on every strobe.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1 without a strobe, the FSM SHALL return to IDLE, pulse seq_err, and leave held unchanged.
REQ-024 If a strobe and the timeout coincide, the strobe SHALL win and seq_err SHALL NOT pulse.
REQ-025 0xE0 or 0xF0 received in any state other than IDLE SHALL be treated as a key byte that matches no key; the sequence completes with no effect.

Reset
REQ-026 While reset=1, the FSM SHALL be in IDLE, held=4'b0000, accel=2'b00, steer=2'b00, estop=0, seq_err=0, the counter SHALL be 0, and both recency bits SHALL be 0.
REQ-027 Reset asserted mid-sequence SHALL discard the partial sequence, so a following lone 0x73 is read as a make.

Structure
REQ-028 Package ps2_drive_pkg SHALL hold the scancode constants, the FSM state encoding, and the accel/steer encodings.
REQ-029 One sub-module, drive_axis_arb, SHALL perform the last-pressed arbitration for one axis and SHALL be instantiated twice, once for accel and once for steer.

Verification
REQ-030 Strobe 0x73, then F0 73: accel goes to 10 one cycle after the 0x73 strobe, and back to 00 one cycle after the 0x73 that follows F0.
REQ-031 Strobe 0x73, then E0 72, then E0 F0 72: accel goes 10, then 01, then 10 again, with held[3:2] reading 11 and then 10.
REQ-032 Strobe 6B and 74, then 0x76: steer goes 10, then 01, then 00; estop pulses for one cycle and held=0000.
REQ-033 Strobe lone 0xE0 and wait TIMEOUT_CYCLES: seq_err pulses once; a following 0x74 sets steer=01, with no extended break inferred.
REQ-034 Strobe 0x73, then F0, then assert reset for one cycle, then strobe 0x73: accel=10 after reset, confirming the break was discarded.

Source files
------------

// File: rtl/ps2_drive_pkg.sv
// ps2_drive_pkg: shared constants for the PS/2 drive controller.
//   - Scancode bytes for prefixes and mapped keys
//   - Decoder FSM state encoding
//   - accel/steer output encodings and held-vector bit positions
//   - key_mask(): maps a completed key byte to a {fwd,back,left,right} mask
package ps2_drive_pkg;

  // Scancode bytes
  localparam logic [7:0] ScE0      = 8'hE0;
  localparam logic [7:0] ScF0      = 8'hF0;
  localparam logic [7:0] ScFwd     = 8'h73;  // keypad 5 (non-extended)
  localparam logic [7:0] ScFwdExt  = 8'h75;  // up arrow (extended)
  localparam logic [7:0] ScBack    = 8'h72;
  localparam logic [7:0] ScLeft    = 8'h6B;
  localparam logic [7:0] ScRight   = 8'h74;
  localparam logic [7:0] ScEsc     = 8'h76;

  // Decoder states
  typedef enum logic [1:0] {
    StIdle,
    StGotE0,
    StGotF0,
    StGotE0F0
  } dec_state_e;

  // Output encodings
  localparam logic [1:0] AccelFwd      = 2'b10;
  localparam logic [1:0] AccelBack     = 2'b01;
  localparam logic [1:0] AccelStop     = 2'b00;
  localparam logic [1:0] SteerLeft     = 2'b10;
  localparam logic [1:0] SteerRight    = 2'b01;
  localparam logic [1:0] SteerStraight = 2'b00;

  // Bit positions inside the held vector
  localparam int unsigned HeldFwd   = 3;
  localparam int unsigned HeldBack  = 2;
  localparam int unsigned HeldLeft  = 1;
  localparam int unsigned HeldRight = 0;

  // Returns the one-hot held mask for a key byte; zero for unmapped codes.
  // Prefix bytes never match, so a stray E0/F0 mid-sequence has no effect.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    logic [3:0] m;
    m = 4'b0000;
    if (ext) begin
      unique case (code)
        ScFwdExt: m[HeldFwd]   = 1'b1;
        ScBack:   m[HeldBack]  = 1'b1;
        ScLeft:   m[HeldLeft]  = 1'b1;
        ScRight:  m[HeldRight] = 1'b1;
        default:  m = 4'b0000;
      endcase
    end else begin
      unique case (code)
        ScFwd:   m[HeldFwd]   = 1'b1;
        ScBack:  m[HeldBack]  = 1'b1;
        ScLeft:  m[HeldLeft]  = 1'b1;
        ScRight: m[HeldRight] = 1'b1;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_drive_ctrl_axis_arb.sv
// drive_axis_arb: last-pressed arbitration for one drive axis.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   clr               - force output to DirNone (emergency stop)
//   press_a, press_b  - new press (not typematic) of key A / key B this cycle
//   held_a, held_b    - next-state held flags of key A / key B
//   dir               - registered direction: DirA, DirB or DirNone
module drive_axis_arb
  import ps2_drive_pkg::*;
#(
  parameter logic [1:0] DirA    = 2'b10,
  parameter logic [1:0] DirB    = 2'b01,
  parameter logic [1:0] DirNone = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       press_a,
  input  logic       press_b,
  input  logic       held_a,
  input  logic       held_b,
  output logic [1:0] dir
);

  // Recency bit: 1 when B was pressed more recently than A.
  logic       last_b_q;
  logic       last_b_d;
  logic [1:0] dir_d;

  always_comb begin
    last_b_d = last_b_q;
    if (press_a) begin
      last_b_d = 1'b0;
    end else if (press_b) begin
      last_b_d = 1'b1;
    end

    unique case ({held_a, held_b})
      2'b10:   dir_d = DirA;
      2'b01:   dir_d = DirB;
      // Both held: the newest press wins; when it breaks, the case above
      // hands the axis back to the survivor on the same update.
      2'b11:   dir_d = last_b_d ? DirB : DirA;
      default: dir_d = DirNone;
    endcase

    if (clr) begin
      dir_d = DirNone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b0;
      dir      <= DirNone;
    end else begin
      last_b_q <= last_b_d;
      dir      <= dir_d;
    end
  end

endmodule

// File: rtl/ps2_drive_ctrl.sv
// ps2_drive_ctrl: decodes PS/2 set-2 scancodes into drive/steer commands.
// Ports:
//   CLOCK_50        - clock (rising edge)
//   reset           - synchronous active-high reset
//   ps2_key_data    - scancode byte, valid when ps2_key_pressed=1
//   ps2_key_pressed - one-cycle byte strobe
//   accel           - 10 forward, 01 backward, 00 stop (registered)
//   steer           - 10 left, 01 right, 00 straight (registered)
//   estop           - one-cycle pulse on ESC make
//   held            - {fwd,back,left,right} held flags (registered)
//   seq_err         - one-cycle pulse when a prefix sequence times out
module ps2_drive_ctrl
  import ps2_drive_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TMR_W          = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [1:0] accel,
  output logic [1:0] steer,
  output logic       estop,
  output logic [3:0] held,
  output logic       seq_err
);

  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

  dec_state_e       state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [3:0]       held_q;
  logic             estop_q;
  logic             seq_err_q;

  logic       is_ext;
  logic       is_brk;
  logic       is_final;
  logic       is_esc;
  logic       timeout_hit;
  logic [3:0] mask;
  logic [3:0] press;
  logic [3:0] held_d;

  // Byte classification for the current strobe.
  always_comb begin
    is_ext   = (state_q == StGotE0) || (state_q == StGotE0F0);
    is_brk   = (state_q == StGotF0) || (state_q == StGotE0F0);
    // Any strobe that does not advance to another prefix state completes a sequence.
    is_final = ps2_key_pressed
             && !((state_q == StIdle) && ((ps2_key_data == ScE0) || (ps2_key_data == ScF0)))
             && !((state_q == StGotE0) && (ps2_key_data == ScF0));
    mask     = key_mask(ps2_key_data, is_ext);
    is_esc   = is_final && !is_ext && !is_brk && (ps2_key_data == ScEsc);

    held_d = held_q;
    press  = 4'b0000;
    if (is_esc) begin
      held_d = 4'b0000;
    end else if (is_final) begin
      if (is_brk) begin
        held_d = held_q & ~mask;
      end else begin
        // Typematic repeats of a held key do not count as a new press.
        press  = mask & ~held_q;
        held_d = held_q | mask;
      end
    end

    // A strobe on the expiry cycle takes priority over the timeout.
    timeout_hit = (state_q != StIdle) && !ps2_key_pressed && (tmr_q == TmrLast);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StIdle;
      tmr_q     <= '0;
      held_q    <= 4'b0000;
      estop_q   <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      estop_q   <= is_esc;
      seq_err_q <= timeout_hit;

      unique case (state_q)
        StIdle: begin
          tmr_q <= '0;
          if (ps2_key_pressed) begin
            if (ps2_key_data == ScE0) begin
              state_q <= StGotE0;
            end else if (ps2_key_data == ScF0) begin
              state_q <= StGotF0;
            end
          end
        end
        StGotE0: begin
          if (ps2_key_pressed) begin
            tmr_q   <= '0;
            state_q <= (ps2_key_data == ScF0) ? StGotE0F0 : StIdle;
          end else if (timeout_hit) begin
            tmr_q   <= '0;
            state_q <= StIdle;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        StGotF0, StGotE0F0: begin
          if (ps2_key_pressed || timeout_hit) begin
            tmr_q   <= '0;
            state_q <= StIdle;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: begin
          tmr_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  drive_axis_arb #(
    .DirA    (AccelFwd),
    .DirB    (AccelBack),
    .DirNone (AccelStop)
  ) u_accel_arb (
    .clk     (CLOCK_50),
    .reset   (reset),
    .clr     (is_esc),
    .press_a (press[HeldFwd]),
    .press_b (press[HeldBack]),
    .held_a  (held_d[HeldFwd]),
    .held_b  (held_d[HeldBack]),
    .dir     (accel)
  );

  drive_axis_arb #(
    .DirA    (SteerLeft),
    .DirB    (SteerRight),
    .DirNone (SteerStraight)
  ) u_steer_arb (
    .clk     (CLOCK_50),
    .reset   (reset),
    .clr     (is_esc),
    .press_a (press[HeldLeft]),
    .press_b (press[HeldRight]),
    .held_a  (held_d[HeldLeft]),
    .held_b  (held_d[HeldRight]),
    .dir     (steer)
  );

  assign held    = held_q;
  assign estop   = estop_q;
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_ps2_drive_ctrl.sv
// tb_ps2_drive_ctrl: directed self-checking bench for ps2_drive_ctrl.
// Uses a short timeout so prefix expiry can be exercised cycle-exactly.
module tb_ps2_drive_ctrl;

  localparam int unsigned T = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic [1:0] accel;
  logic [1:0] steer;
  logic       estop;
  logic [3:0] held;
  logic       seq_err;

  int n_checks = 0;
  int n_fail   = 0;
  int seq_pulses = 0;
  int seq_base;

  ps2_drive_ctrl #(
    .TIMEOUT_CYCLES (T),
    .TMR_W          (5)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .accel           (accel),
    .steer           (steer),
    .estop           (estop),
    .held            (held),
    .seq_err         (seq_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (seq_err === 1'b1) seq_pulses++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte on the next rising edge; returns 1ns after that edge.
  task automatic strobe(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(posedge CLOCK_50);
    #1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    // Reset state
    idle(2);
    reset = 1'b0;
    check("rst_accel", {6'd0, accel}, 8'h00);
    check("rst_steer", {6'd0, steer}, 8'h00);
    check("rst_held", {4'd0, held}, 8'h00);
    check("rst_estop", {7'd0, estop}, 8'h00);
    check("rst_seq_err", {7'd0, seq_err}, 8'h00);

    // Forward make then break
    strobe(8'h73);
    check("fwd_make_accel", {6'd0, accel}, 8'h02);
    check("fwd_make_held", {4'd0, held}, 8'h08);
    strobe(8'hF0);
    check("fwd_f0_pending", {6'd0, accel}, 8'h02);
    strobe(8'h73);
    check("fwd_break_accel", {6'd0, accel}, 8'h00);
    check("fwd_break_held", {4'd0, held}, 8'h00);

    // Forward, extended back, typematic forward, extended back break
    strobe(8'h73);
    check("arb_fwd", {6'd0, accel}, 8'h02);
    strobe(8'hE0);
    strobe(8'h72);
    check("arb_back_wins", {6'd0, accel}, 8'h01);
    check("arb_held_both", {6'd0, held[3:2]}, 8'h03);
    strobe(8'h73);
    check("arb_typematic", {6'd0, accel}, 8'h01);
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h72);
    check("arb_fwd_takeover", {6'd0, accel}, 8'h02);
    check("arb_held_fwd", {6'd0, held[3:2]}, 8'h02);
    strobe(8'hF0);
    strobe(8'h73);
    check("arb_all_released", {6'd0, accel}, 8'h00);

    // Steer axis, takeover, then ESC
    strobe(8'h6B);
    check("steer_left", {6'd0, steer}, 8'h02);
    strobe(8'h74);
    check("steer_right_wins", {6'd0, steer}, 8'h01);
    check("steer_held", {4'd0, held}, 8'h03);
    strobe(8'hF0);
    strobe(8'h74);
    check("steer_left_takeover", {6'd0, steer}, 8'h02);
    strobe(8'h74);
    check("steer_right_again", {6'd0, steer}, 8'h01);
    strobe(8'h73);
    strobe(8'h76);
    check("esc_estop", {7'd0, estop}, 8'h01);
    check("esc_steer", {6'd0, steer}, 8'h00);
    check("esc_accel", {6'd0, accel}, 8'h00);
    check("esc_held", {4'd0, held}, 8'h00);
    idle(1);
    check("esc_estop_one_cycle", {7'd0, estop}, 8'h00);

    // Unmapped codes and stray prefixes
    strobe(8'h1C);
    check("unmapped_held", {4'd0, held}, 8'h00);
    strobe(8'hE0);
    strobe(8'hE0);
    strobe(8'h73);
    check("stray_e0_then_fwd", {6'd0, accel}, 8'h02);
    strobe(8'hE0);
    strobe(8'h76);
    check("ext_esc_no_estop", {7'd0, estop}, 8'h00);
    check("ext_esc_held", {4'd0, held}, 8'h08);
    strobe(8'hF0);
    strobe(8'h73);
    check("stray_cleanup", {4'd0, held}, 8'h00);

    // Lone E0 times out after exactly T cycles
    seq_base = seq_pulses;
    strobe(8'hE0);
    idle(T - 1);
    check("timeout_not_early", {7'd0, seq_err}, 8'h00);
    idle(1);
    check("timeout_pulse", {7'd0, seq_err}, 8'h01);
    idle(4);
    check("timeout_pulse_count", 8'(seq_pulses - seq_base), 8'h01);
    check("timeout_held_kept", {4'd0, held}, 8'h00);
    strobe(8'h74);
    check("after_timeout_steer", {6'd0, steer}, 8'h01);
    check("after_timeout_held", {4'd0, held}, 8'h01);

    // Strobe on the expiry cycle wins over the timeout
    seq_base = seq_pulses;
    strobe(8'hE0);
    idle(T - 1);
    strobe(8'h75);
    check("coincide_no_seq_err", {7'd0, seq_err}, 8'h00);
    check("coincide_ext_fwd", {6'd0, accel}, 8'h02);
    idle(T + 2);
    check("coincide_pulse_count", 8'(seq_pulses - seq_base), 8'h00);

    // Reset mid-sequence discards the pending break
    strobe(8'hF0);
    strobe(8'h73);
    strobe(8'h73);
    strobe(8'hF0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midrst_held", {4'd0, held}, 8'h00);
    check("midrst_accel", {6'd0, accel}, 8'h00);
    strobe(8'h73);
    check("midrst_fwd_make", {6'd0, accel}, 8'h02);
    check("midrst_held_fwd", {4'd0, held}, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
